// File: rtl/simd_vector_unit.sv
// simd_vector_unit: packed-SIMD integer unit with runtime element width
// (8/16/32/64) and an elastic valid/ready pipeline. The operation is
// evaluated combinationally from the accepted inputs and captured in
// stage 0. The remaining stages only carry the result toward the output.
module simd_vector_unit #(
    parameter int XLEN        = 64,
    parameter int PIPE_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      opcode,
    input  logic [1:0]      ew,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            sat,
    output logic            illegal
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_ADDUS, OP_MIN, OP_MAX, OP_MINU,
        OP_MAXU, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_REDSUM
    } op_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            sat;
        logic            illegal;
    } stage_t;

    op_e             op;
    logic [XLEN-1:0] res_w [4];
    logic [3:0]      sat_w;

    assign op = op_e'(opcode[3:0]);

    // One datapath per element width; ew picks one of them afterwards.
    for (genvar w = 0; w < 4; w++) begin : g_width
        localparam int EW = 8 << w;
        localparam int NL = XLEN / EW;
        localparam int SH = 3 + w;
        localparam logic [EW-1:0] SMAX = {1'b0, {(EW-1){1'b1}}};
        localparam logic [EW-1:0] SMIN = {1'b1, {(EW-1){1'b0}}};

        logic [XLEN-1:0] res;
        logic [NL-1:0]   lane_sat;
        logic [EW-1:0]   red_sum;

        // Wrapping sum of every op_a lane, used by REDSUM in lane 0.
        // NOTE: combinational blocks use blocking '=' so each line sees the
        // previous line's value; clocked blocks use '<=' only.
        always_comb begin
            red_sum = '0;
            for (int l = 0; l < NL; l++) begin
                red_sum = red_sum + op_a[l*EW +: EW];
            end
        end

        for (genvar l = 0; l < NL; l++) begin : g_lane
            logic [EW-1:0] a, b, sum, diff, r;
            logic [EW:0]   usum;
            logic [SH-1:0] shamt;
            logic          add_ovf, sub_ovf, s;

            assign a       = op_a[l*EW +: EW];
            assign b       = op_b[l*EW +: EW];
            assign sum     = a + b;
            assign diff    = a - b;
            assign usum    = {1'b0, a} + {1'b0, b};
            assign shamt   = b[SH-1:0];
            assign add_ovf = (a[EW-1] == b[EW-1]) && (sum[EW-1] != a[EW-1]);
            assign sub_ovf = (a[EW-1] != b[EW-1]) && (diff[EW-1] != a[EW-1]);

            // Per-lane operation select; only the saturating ops raise s.
            // NOTE: r and s get defaults before the case so no path leaves
            // them unassigned, which would otherwise infer a latch.
            always_comb begin
                r = '0;
                s = 1'b0;
                case (op)
                    OP_ADD:    r = sum;
                    OP_SUB:    r = diff;
                    OP_ADDS: begin
                        s = add_ovf;
                        r = add_ovf ? (a[EW-1] ? SMIN : SMAX) : sum;
                    end
                    OP_SUBS: begin
                        s = sub_ovf;
                        r = sub_ovf ? (a[EW-1] ? SMIN : SMAX) : diff;
                    end
                    OP_ADDUS: begin
                        s = usum[EW];
                        r = usum[EW] ? {EW{1'b1}} : usum[EW-1:0];
                    end
                    OP_MIN:    r = ($signed(a) < $signed(b)) ? a : b;
                    OP_MAX:    r = ($signed(a) > $signed(b)) ? a : b;
                    OP_MINU:   r = (a < b) ? a : b;
                    OP_MAXU:   r = (a > b) ? a : b;
                    OP_AND:    r = a & b;
                    OP_OR:     r = a | b;
                    OP_XOR:    r = a ^ b;
                    OP_SLL:    r = a << shamt;
                    OP_SRL:    r = a >> shamt;
                    OP_SRA:    r = $signed(a) >>> shamt;
                    OP_REDSUM: r = (l == 0) ? red_sum : '0;
                    default:   r = '0;
                endcase
            end

            assign res[l*EW +: EW] = r;
            assign lane_sat[l]     = s;
        end

        assign res_w[w] = res;
        assign sat_w[w] = |lane_sat;
    end

    stage_t                 comp_d;
    stage_t                 data_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] adv;

    // Pick the active width; opcodes 16-31 force a zero result and no sat.
    always_comb begin
        comp_d.illegal = opcode[4];
        comp_d.result  = opcode[4] ? '0 : res_w[ew];
        comp_d.sat     = !opcode[4] && sat_w[ew];
    end

    // A stage advances when out_ready is high or any later stage is empty.
    always_comb begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k + 1; j < PIPE_STAGES; j++) begin
                if (!valid_q[j]) adv[k] = 1'b1;
            end
        end
    end

    assign in_ready = rst_n && (!valid_q[0] || adv[0]);

    // Stage valid bits; reset drops every in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (!valid_q[0] || adv[0]) valid_q[0] <= in_valid;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (!valid_q[k] || adv[k]) valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Stage payloads move in lockstep with the valid bits.
    // NOTE: payload registers are deliberately not reset; every output is
    // gated by out_valid, so stale contents never become visible.
    always_ff @(posedge clk) begin
        if (!valid_q[0] || adv[0]) data_q[0] <= comp_d;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (!valid_q[k] || adv[k]) data_q[k] <= data_q[k-1];
        end
    end

    assign out_valid = valid_q[PIPE_STAGES-1];
    assign result    = out_valid ? data_q[PIPE_STAGES-1].result : '0;
    assign sat       = out_valid && data_q[PIPE_STAGES-1].sat;
    assign illegal   = out_valid && data_q[PIPE_STAGES-1].illegal;

endmodule
